multicycle_ctrl_fsm: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 56 +++++
 rtl/alu_op_decoder.sv | 41 ++++
 rtl/multicycle_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: FSM states, opcodes, ALU codes
// and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_AND  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps ALU operation class plus instruction function fields to an ALU control
// code; funct_legal flags funct3 values this core implements.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_op_5,
  output logic [2:0] o_alu_control,
  output logic       o_funct_legal
);

  always_comb begin
    o_funct_legal = 1'b0;
    case (i_funct3)
      3'b000, 3'b010, 3'b110, 3'b111: o_funct_legal = 1'b1;
      default:                        o_funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    o_alu_control = ALU_NONE;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // op_code[5] separates R-type from I-type, so addi never becomes sub
          3'b000:  o_alu_control = (i_op_5 && i_funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_NONE;
        endcase
      end
      default: o_alu_control = ALU_NONE;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I sequencer: steps each instruction through its states and
// drives datapath selects/enables, a retired counter and a sticky trap flag.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op_code,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             reg_write,
  output logic [CNT_W-1:0] instr_retired,
  output logic             illegal
);

  state_t           r_state;
  state_t           w_next;
  alu_op_t          w_alu_op;
  logic [2:0]       w_alu_control;
  logic             w_funct_legal;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;

  alu_op_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_funct7_5    (funct7_5),
    .i_op_5        (op_code[5]),
    .o_alu_control (w_alu_control),
    .o_funct_legal (w_funct_legal)
  );

  always_comb begin
    w_alu_op = ALUOP_ADD;
    case (r_state)
      EXECUTER, EXECUTEI: w_alu_op = ALUOP_FUNCT;
      BEQ:                w_alu_op = ALUOP_SUB;
      default:            w_alu_op = ALUOP_ADD;
    endcase
  end

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      FETCH:  if (mem_ready) w_next = DECODE;
      DECODE: begin
        case (op_code)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = w_funct_legal ? EXECUTER : TRAP;
          OP_I:         w_next = w_funct_legal ? EXECUTEI : TRAP;
          OP_BEQ:       w_next = BEQ;
          OP_JAL:       w_next = JAL;
          default:      w_next = TRAP;
        endcase
      end
      MEMADR:   w_next = (op_code == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ready) w_next = MEMWB;
      MEMWB:    begin w_next = FETCH; w_retire = 1'b1; end
      MEMWRITE: if (mem_ready) begin w_next = FETCH; w_retire = 1'b1; end
      EXECUTER, EXECUTEI: w_next = ALUWB;
      ALUWB:    begin w_next = FETCH; w_retire = 1'b1; end
      BEQ:      begin w_next = FETCH; w_retire = 1'b1; end
      JAL:      w_next = ALUWB;
      TRAP:     w_next = TRAP;
      default:  w_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      if (w_next == TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = ADR_PC;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_NONE;
    reg_write   = 1'b0;
    imm_src     = (r_state == FETCH) ? IMM_I : imm_src_of(op_code);
    case (r_state)
      FETCH: begin
        alu_src_b   = SRCB_FOUR;
        alu_control = w_alu_control;
        result_src  = RES_ALURESULT;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
      end
      DECODE: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_IMM;
        alu_control = w_alu_control;
      end
      MEMADR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = w_alu_control;
      end
      MEMREAD:  adr_src = ADR_ALUOUT;
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a   = SRCA_RS1;
        alu_control = w_alu_control;
      end
      EXECUTEI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = w_alu_control;
      end
      ALUWB:    reg_write = 1'b1;
      BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = w_alu_control;
        pc_write    = zero;
      end
      JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_control = w_alu_control;
        pc_write    = 1'b1;
      end
      default: ;
    endcase
    // reset returns the state to FETCH immediately, whose enables follow mem_ready
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign instr_retired = r_retired;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboarded bench for multicycle_ctrl_fsm: per-cycle expected control words
// are queued with their stimulus and compared as the FSM steps.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  op_code = 7'b0110011;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7_5 = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] instr_retired;

  multicycle_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write),
    .instr_retired(instr_retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] bus;
  assign bus = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write, illegal};

  typedef struct packed {
    logic        mr;
    logic        z;
    logic [16:0] exp;
    logic        inc;
  } item_t;

  item_t       sb[$];
  item_t       it;
  int          checks = 0;
  int          failures = 0;
  int          cyc;
  logic [31:0] exp_ret = '0;

  function automatic logic [16:0] cv(input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, a, b, imm,
                                     input logic [2:0] alu, input logic rw, ill);
    return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
  endfunction

  function automatic logic [16:0] e_fetch(input logic mr);
    return cv(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, 3'b010, 0, 0);
  endfunction
  function automatic logic [16:0] e_decode(input logic [1:0] imm);
    return cv(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b010, 0, 0);
  endfunction
  function automatic logic [16:0] e_memadr(input logic [1:0] imm);
    return cv(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b010, 0, 0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [1:0] b, input logic [2:0] alu);
    return cv(0, 0, 0, 0, 2'b00, 2'b10, b, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
    return cv(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction

  localparam logic [16:0] RST_VEC = 17'b0_0_0_0_10_00_10_00_010_0_0;
  localparam logic [16:0] TRAP_VEC = 17'b0_0_0_0_00_00_00_00_000_0_1;

  task automatic push(input logic mr, input logic z, input logic [16:0] e, input logic inc);
    sb.push_back('{mr: mr, z: z, exp: e, inc: inc});
  endtask

  task automatic set_insn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_code = op; funct3 = f3; funct7_5 = f7;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus !== RST_VEC) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=%b", bus, RST_VEC);
    end
    checks++;
    if (instr_retired !== 32'd0) begin
      failures++; $display("FAIL reset_retired got=%0d exp=0", instr_retired);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_add();
    set_insn(7'b0110011, 3'b000, 1'b0);
    push(1, 0, e_fetch(1), 0);
    push(1, 0, e_decode(2'b00), 0);
    push(1, 0, e_exec(2'b00, 3'b010), 0);
    push(1, 0, e_aluwb(2'b00), 1);
    cyc = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      checks++;
      if (bus !== it.exp) begin
        failures++; $display("FAIL add_c%0d got=%b exp=%b", cyc, bus, it.exp);
      end
      if (it.inc) exp_ret++;
      cyc++;
    end
    @(posedge clk); #1;
    checks++;
    if (instr_retired !== exp_ret) begin
      failures++; $display("FAIL add_retired got=%0d exp=%0d", instr_retired, exp_ret);
    end
  endtask

  task automatic test_sub_addi();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set_insn(7'b0110011, 3'b000, 1'b1);
        push(1, 0, e_fetch(1), 0);
        push(1, 0, e_decode(2'b00), 0);
        push(1, 0, e_exec(2'b00, 3'b011), 0);
      end else begin
        set_insn(7'b0010011, 3'b000, 1'b1);
        push(1, 0, e_fetch(1), 0);
        push(1, 0, e_decode(2'b00), 0);
        push(1, 0, e_exec(2'b01, 3'b010), 0);
      end
      push(1, 0, e_aluwb(2'b00), 1);
      cyc = 0;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
        checks++;
        if (bus !== it.exp) begin
          failures++; $display("FAIL subaddi%0d_c%0d got=%b exp=%b", k, cyc, bus, it.exp);
        end
        if (it.inc) exp_ret++;
        cyc++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instr_retired !== exp_ret) begin
      failures++; $display("FAIL subaddi_retired got=%0d exp=%0d", instr_retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait();
    set_insn(7'b0000011, 3'b010, 1'b0);
    push(1, 0, e_fetch(1), 0);
    push(1, 0, e_decode(2'b00), 0);
    push(1, 0, e_memadr(2'b00), 0);
    for (int i = 0; i < 3; i++)
      push(0, 0, cv(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), 0);
    push(1, 0, cv(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0), 0);
    push(1, 0, cv(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0), 1);
    cyc = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      checks++;
      if (bus !== it.exp) begin
        failures++; $display("FAIL lw_c%0d got=%b exp=%b", cyc, bus, it.exp);
      end
      if (it.inc) exp_ret++;
      cyc++;
    end
    @(posedge clk); #1;
    checks++;
    if (instr_retired !== exp_ret) begin
      failures++; $display("FAIL lw_retired got=%0d exp=%0d", instr_retired, exp_ret);
    end
  endtask

  task automatic test_sw();
    set_insn(7'b0100011, 3'b010, 1'b0);
    push(0, 0, e_fetch(0), 0);
    push(1, 0, e_fetch(1), 0);
    push(1, 0, e_decode(2'b01), 0);
    push(1, 0, e_memadr(2'b01), 0);
    push(1, 0, cv(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0, 0), 1);
    cyc = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      checks++;
      if (bus !== it.exp) begin
        failures++; $display("FAIL sw_c%0d got=%b exp=%b", cyc, bus, it.exp);
      end
      if (it.inc) exp_ret++;
      cyc++;
    end
    @(posedge clk); #1;
    checks++;
    if (instr_retired !== exp_ret) begin
      failures++; $display("FAIL sw_retired got=%0d exp=%0d", instr_retired, exp_ret);
    end
  endtask

  task automatic test_beq_jal();
    set_insn(7'b1100011, 3'b000, 1'b0);
    for (int zb = 1; zb >= 0; zb--) begin
      push(1, 0, e_fetch(1), 0);
      push(1, 0, e_decode(2'b10), 0);
      push(1, zb[0], cv(zb[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b011, 0, 0), 1);
    end
    cyc = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      checks++;
      if (bus !== it.exp) begin
        failures++; $display("FAIL beq_c%0d got=%b exp=%b", cyc, bus, it.exp);
      end
      if (it.inc) exp_ret++;
      cyc++;
    end
    @(posedge clk); #1;
    set_insn(7'b1101111, 3'b000, 1'b0);
    push(1, 0, e_fetch(1), 0);
    push(1, 0, e_decode(2'b11), 0);
    push(1, 0, cv(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b010, 0, 0), 0);
    push(1, 0, e_aluwb(2'b11), 1);
    cyc = 0;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
      checks++;
      if (bus !== it.exp) begin
        failures++; $display("FAIL jal_c%0d got=%b exp=%b", cyc, bus, it.exp);
      end
      if (it.inc) exp_ret++;
      cyc++;
    end
    @(posedge clk); #1;
    checks++;
    if (instr_retired !== exp_ret) begin
      failures++; $display("FAIL beqjal_retired got=%0d exp=%0d", instr_retired, exp_ret);
    end
  endtask

  task automatic test_trap();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_insn(7'b1111111, 3'b000, 1'b0);
      else        set_insn(7'b0110011, 3'b001, 1'b0);
      push(1, 0, e_fetch(1), 0);
      push(1, 0, e_decode(2'b00), 0);
      for (int i = 0; i < 3; i++) push(1, 1, TRAP_VEC, 0);
      cyc = 0;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        @(negedge clk); mem_ready = it.mr; zero = it.z; #1;
        checks++;
        if (bus !== it.exp) begin
          failures++; $display("FAIL trap%0d_c%0d got=%b exp=%b", k, cyc, bus, it.exp);
        end
        if (it.inc) exp_ret++;
        cyc++;
      end
      @(negedge clk); #2 rst = 1'b1; #1;
      exp_ret = '0;
      checks++;
      if (bus !== RST_VEC) begin
        failures++; $display("FAIL trap%0d_async_rst got=%b exp=%b", k, bus, RST_VEC);
      end
      checks++;
      if (instr_retired !== exp_ret) begin
        failures++; $display("FAIL trap%0d_rst_retired got=%0d exp=0", k, instr_retired);
      end
      @(posedge clk); #1 rst = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_addi();
    test_lw_wait();
    test_sw();
    test_beq_jal();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
